// File: rtl/approx_mult_error_monitor.sv
// Error-statistics monitor for approximate WIDTHxWIDTH multipliers: exact recompute, ED sum/max/count.
// Optional signed bias accumulator compiled in with APPROX_MON_BIAS_EN.
module approx_mult_error_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 17,
  parameter int ACC_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  input  logic [2*WIDTH-1:0] z_approx,
  output logic               busy,
  output logic               done,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [2*WIDTH-1:0] max_ed,
  output logic [CNT_W-1:0]   err_count,
  output logic               sum_sat,
  output logic [ACC_W:0]     bias_sum
);
  localparam int PW = 2*WIDTH;
  // Adder wide enough for both operands plus a carry, whichever of ACC_W / PW is larger.
  localparam int SW = ((ACC_W > PW) ? ACC_W : PW) + 1;
  localparam logic [SW-1:0] ACC_MAX = {{(SW-ACC_W){1'b0}}, {ACC_W{1'b1}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             in_ready_q, in_ready_d, busy_q, busy_d, done_q, done_d;
  logic [2:1]       vld_pipe_q, vld_pipe_d;
  logic [PW-1:0]    exact_q, exact_d, zap_q, zap_d, ed_q, ed_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [PW-1:0]    max_ed_q, max_ed_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             sat_q, sat_d;
  logic [SW-1:0]    sum_ext;
  logic             accept, clr;

  always_comb begin
    accept  = in_valid && in_ready_q;
    clr     = (state_q == IDLE) && start;
    state_d = state_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: if (start) begin
        rem_d   = num_samples;
        state_d = (num_samples == '0) ? DONE : RUN;
      end
      RUN: if (accept) begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = DRAIN;
      end
      DRAIN:   if (vld_pipe_q == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    in_ready_d = (state_d == RUN);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
    done_d     = (state_d == DONE);
  end

  // Pipeline datapath loads every cycle; only the valid bits gate the accumulators.
  always_comb begin
    vld_pipe_d = {vld_pipe_q[1], accept};
    exact_d    = PW'(x) * PW'(y);
    zap_d      = z_approx;
    ed_d       = (zap_q >= exact_q) ? (zap_q - exact_q) : (exact_q - zap_q);
    sum_ext    = SW'(sum_ed_q) + SW'(ed_q);
    sum_ed_d   = sum_ed_q;
    max_ed_d   = max_ed_q;
    err_d      = err_q;
    sat_d      = sat_q;
    if (vld_pipe_q[2]) begin
      if (sum_ext > ACC_MAX) begin
        sum_ed_d = '1;
        sat_d    = 1'b1;
      end else begin
        sum_ed_d = sum_ext[ACC_W-1:0];
      end
      if (ed_q > max_ed_q) max_ed_d = ed_q;
      if (ed_q != '0)      err_d    = err_q + CNT_W'(1);
    end
    if (clr) begin
      sum_ed_d = '0;
      max_ed_d = '0;
      err_d    = '0;
      sat_d    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rem_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      vld_pipe_q <= '0;
      exact_q    <= '0;
      zap_q      <= '0;
      ed_q       <= '0;
      sum_ed_q   <= '0;
      max_ed_q   <= '0;
      err_q      <= '0;
      sat_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      vld_pipe_q <= vld_pipe_d;
      exact_q    <= exact_d;
      zap_q      <= zap_d;
      ed_q       <= ed_d;
      sum_ed_q   <= sum_ed_d;
      max_ed_q   <= max_ed_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
    end
  end

`ifdef APPROX_MON_BIAS_EN
  logic signed [PW:0] diff_q, diff_d;
  logic [ACC_W:0]     bias_q, bias_d;

  // Bias wraps silently; sign extension comes from the signed size cast.
  always_comb begin
    diff_d = signed'({1'b0, zap_q}) - signed'({1'b0, exact_q});
    bias_d = bias_q;
    if (vld_pipe_q[2]) bias_d = bias_q + (ACC_W+1)'(diff_q);
    if (clr)           bias_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_q <= '0;
      bias_q <= '0;
    end else begin
      diff_q <= diff_d;
      bias_q <= bias_d;
    end
  end

  assign bias_sum = bias_q;
`else
  assign bias_sum = '0;
`endif

  assign in_ready  = in_ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;
  assign err_count = err_q;
  assign sum_sat   = sat_q;

endmodule

// File: tb/tb_approx_mult_error_monitor.sv
// Bench for approx_mult_error_monitor: default instance plus an ACC_W=8 instance on shared stimulus.
module tb_approx_mult_error_monitor;
  localparam int W = 8, CW = 17;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, in_valid = 1'b0;
  logic [CW-1:0]  num_samples = '0;
  logic [W-1:0]   x = '0, y = '0;
  logic [2*W-1:0] z_approx = '0;

  logic in_ready, busy, done, sum_sat;
  logic [31:0] sum_ed; logic [15:0] max_ed; logic [CW-1:0] err_count; logic [32:0] bias_sum;
  logic in_ready8, busy8, done8, sum_sat8;
  logic [7:0] sum_ed8; logic [15:0] max_ed8; logic [CW-1:0] err_count8; logic [8:0] bias_sum8;

  approx_mult_error_monitor dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy), .done(done), .sum_ed(sum_ed), .max_ed(max_ed),
    .err_count(err_count), .sum_sat(sum_sat), .bias_sum(bias_sum));

  approx_mult_error_monitor #(.ACC_W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_samples(num_samples),
    .in_valid(in_valid), .in_ready(in_ready8), .x(x), .y(y), .z_approx(z_approx),
    .busy(busy8), .done(done8), .sum_ed(sum_ed8), .max_ed(max_ed8),
    .err_count(err_count8), .sum_sat(sum_sat8), .bias_sum(bias_sum8));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;
  int pcnt = 0;
  always @(posedge clk) pcnt <= pcnt + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {int edge_n; int a; int b; int c;} samp_t;
  samp_t  q[$];
  bit     m_ready, m_done, running, m_sat32, m_sat8;
  longint m_sum32, m_sum8, m_max, m_err, m_bias;
  int     cyc = 0, done_at = -1, remaining = 0;

  task automatic clear_results();
    m_sum32 = 0; m_sum8 = 0; m_max = 0; m_err = 0; m_bias = 0; m_sat32 = 0; m_sat8 = 0;
  endtask

  task automatic model_reset();
    q.delete(); clear_results();
    m_ready = 0; m_done = 0; running = 0; done_at = -1; remaining = 0;
  endtask

  task automatic apply(input samp_t s);
    longint d, ed;
    d  = longint'(s.c) - longint'(s.a * s.b);
    ed = (d < 0) ? -d : d;
    if (m_sum32 + ed > 64'hFFFF_FFFF) begin m_sum32 = 64'hFFFF_FFFF; m_sat32 = 1; end
    else m_sum32 = m_sum32 + ed;
    if (m_sum8 + ed > 255) begin m_sum8 = 255; m_sat8 = 1; end
    else m_sum8 = m_sum8 + ed;
    if (ed > m_max) m_max = ed;
    if (ed != 0) m_err++;
    m_bias = m_bias + d;
  endtask

  task automatic model_step();
    bit prev_done;
    cyc++;
    prev_done = m_done;
    m_done = 0;
    while (q.size() > 0 && q[0].edge_n == cyc - 2) apply(q.pop_front());
    if (running && cyc == done_at) begin running = 0; m_done = 1; end
    if (m_ready && in_valid) begin
      q.push_back('{cyc, int'(x), int'(y), int'(z_approx)});
      remaining--;
      if (remaining == 0) begin m_ready = 0; done_at = cyc + 3; end
    end
    if (start && !running && !prev_done) begin
      clear_results();
      if (num_samples == '0) m_done = 1;
      else begin running = 1; m_ready = 1; remaining = int'(num_samples); end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) model_reset(); else model_step();
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    chk("in_ready",   longint'(in_ready),   longint'(m_ready));
    chk("busy",       longint'(busy),       longint'(running));
    chk("done",       longint'(done),       longint'(m_done));
    chk("sum_ed",     longint'(sum_ed),     m_sum32);
    chk("max_ed",     longint'(max_ed),     m_max);
    chk("err_count",  longint'(err_count),  m_err);
    chk("sum_sat",    longint'(sum_sat),    longint'(m_sat32));
    chk("in_ready8",  longint'(in_ready8),  longint'(m_ready));
    chk("done8",      longint'(done8),      longint'(m_done));
    chk("busy8",      longint'(busy8),      longint'(running));
    chk("sum_ed8",    longint'(sum_ed8),    m_sum8);
    chk("sum_sat8",   longint'(sum_sat8),   longint'(m_sat8));
    chk("max_ed8",    longint'(max_ed8),    m_max);
    chk("err_count8", longint'(err_count8), m_err);
`ifdef APPROX_MON_BIAS_EN
    chk("bias_sum",   longint'(bias_sum),   m_bias & 64'h1_FFFF_FFFF);
    chk("bias_sum8",  longint'(bias_sum8),  m_bias & 64'h1FF);
`else
    chk("bias_sum",   longint'(bias_sum),   0);
    chk("bias_sum8",  longint'(bias_sum8),  0);
`endif
  end

  // ---------------- stimulus helpers (all called at a negedge) ----------------
  task automatic do_start(input int n);
    @(negedge clk); start = 1'b1; num_samples = CW'(n);
    @(negedge clk); start = 1'b0;
  endtask

  task automatic feed(input int a, input int b, input int c);
    bit got = 0;
    x = W'(a); y = W'(b); z_approx = 16'(c); in_valid = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      got = in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("feed_accepted", longint'(got), 1);
  endtask

  task automatic wait_done(input string nm);
    bit seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    chk(nm, longint'(seen), 1);
  endtask

  int gv[8] = '{1, 0, 1, 1, 0, 1, 1, 1};
  int gx[8] = '{2, 0, 20, 100, 0, 0, 1, 1};
  int gy[8] = '{3, 0, 20, 100, 0, 9, 1, 1};
  int gz[8] = '{6, 0, 390, 10010, 0, 1, 77, 77};

  initial begin
    int acc_n, acc_p, lat;
    bit seen;

    repeat (2) @(negedge clk);
    chk("rst_sum_ed", longint'(sum_ed), 0);
    chk("rst_busy",   longint'(busy),   0);
    chk("rst_ready",  longint'(in_ready), 0);
    chk("rst_done",   longint'(done),   0);
    rst_n = 1'b1;

    // exact product: no error
    do_start(1);
    feed(3, 5, 15);
    wait_done("done_run1");
    chk("run1_sum", longint'(sum_ed), 0);
    chk("run1_err", longint'(err_count), 0);

    // mixed errors: ed 25, 12, 0
    do_start(3);
    feed(255, 255, 65000);
    feed(10, 10, 112);
    feed(4, 4, 16);
    wait_done("done_run2");
    chk("run2_sum", longint'(sum_ed), 37);
    chk("run2_max", longint'(max_ed), 25);
    chk("run2_err", longint'(err_count), 2);
`ifdef APPROX_MON_BIAS_EN
    chk("run2_bias", longint'($signed(bias_sum)), -13);
`endif

    // gaps plus an extra sample that must not be consumed
    do_start(4);
    acc_n = 0; acc_p = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = gv[i][0]; x = W'(gx[i]); y = W'(gy[i]); z_approx = 16'(gz[i]);
      if (in_valid && in_ready) begin acc_n++; acc_p = pcnt; end
      @(negedge clk);
    end
    in_valid = 1'b0;
    seen = 0; lat = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = done;
      lat = pcnt - (acc_p + 1);
    end
    chk("gap_done_seen", longint'(seen), 1);
    chk("gap_accepts", acc_n, 4);
    chk("gap_latency_2_3", longint'(lat >= 2 && lat <= 3), 1);
    chk("gap_sum", longint'(sum_ed), 21);
    chk("gap_max", longint'(max_ed), 10);
    chk("gap_err", longint'(err_count), 3);

    // zero-length run
    do_start(0);
    chk("zero_done", longint'(done), 1);
    chk("zero_sum", longint'(sum_ed), 0);
    chk("zero_max", longint'(max_ed), 0);

    // start during RUN ignored; ACC_W=8 instance saturates
    do_start(2);
    feed(0, 0, 200);
    start = 1'b1; num_samples = CW'(5);
    @(negedge clk); start = 1'b0;
    feed(0, 0, 200);
    wait_done("done_sat");
    chk("sat_sum32", longint'(sum_ed), 400);
    chk("sat_err", longint'(err_count), 2);
    chk("sat_sum8", longint'(sum_ed8), 255);
    chk("sat_flag8", longint'(sum_sat8), 1);
    chk("sat_flag32", longint'(sum_sat), 0);
    do_start(1);
    chk("sat8_cleared", longint'(sum_sat8), 0);
    feed(1, 1, 1);
    wait_done("done_after_sat");

    // reset mid-run
    do_start(5);
    feed(1, 2, 9);
    feed(3, 3, 0);
    repeat (2) @(negedge clk);
    chk("pre_rst_sum", longint'(sum_ed), 16);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_sum", longint'(sum_ed), 0);
    chk("midrst_err", longint'(err_count), 0);
    chk("midrst_max", longint'(max_ed), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_start(1);
    feed(2, 2, 7);
    wait_done("done_post_rst");
    chk("post_rst_sum", longint'(sum_ed), 3);
    chk("post_rst_err", longint'(err_count), 1);

    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/approx_mult_error_monitor.md
Name: approx_mult_error_monitor

Overview:
- Downstream consumer of the 8x8 unsigned approximate multipliers.
- Each accepted sample carries operands x and y and the approximate product z_approx. The block recomputes the exact product and accumulates error statistics over a programmed number of samples.
- Statistics: sum of error distances, maximum error distance, and erroneous-sample count.
- Used on-chip and in benches to characterise each approximate multiplier variant. Feeding all 65536 operand pairs gives an exhaustive characterisation.

Parameters:
- WIDTH, 8, operand width; products are 2*WIDTH bits.
- CNT_W, 17, width of the sample counter and num_samples; must hold 2^(2*WIDTH).
- ACC_W, 32, width of the error-distance accumulator.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse that begins a measurement run.
- num_samples  input  CNT_W  samples in the run; sampled on start.
- in_valid  input  1  sample valid.
- in_ready  output  1  block accepts a sample this cycle.
- x  input  WIDTH  operand x.
- y  input  WIDTH  operand y.
- z_approx  input  2*WIDTH  approximate product from the multiplier under test.
- busy  output  1  run in progress (RUN or DRAIN).
- done  output  1  one-cycle pulse when results are final.
- sum_ed  output  ACC_W  sum of |z_approx - x*y|.
- max_ed  output  2*WIDTH  maximum |z_approx - x*y|.
- err_count  output  CNT_W  samples with z_approx != x*y.
- sum_sat  output  1  sum_ed saturated during the run.
- bias_sum  output  ACC_W+1  signed sum of (z_approx - x*y); optional feature.

Behaviour:

Reset:
- All outputs, counters and pipeline registers are 0. FSM is in IDLE.

FSM, four states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start with num_samples!=0: clear sum_ed, max_ed, err_count, sum_sat and bias_sum; load the remaining counter from num_samples; go to RUN.
  - start with num_samples==0: clear the results and go to DONE.
- RUN:
  - in_ready=1, busy=1.
  - A sample is accepted when in_valid && in_ready. Each accept decrements the remaining counter.
  - The accept that brings the counter to 0 moves the FSM to DRAIN. in_ready is 0 from the next cycle.
  - in_valid with in_ready=0 is not consumed.
- DRAIN:
  - in_ready=0, busy=1.
  - Wait until both pipeline stages are empty (at most 2 cycles), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0; return to IDLE.

Results:
- Results hold their values after done until the next start.
- start while in RUN, DRAIN or DONE is ignored.

Pipeline (2 stages, no stalls):
- Stage 1 registers exact = x*y (full 2*WIDTH bits, exact) and z_approx, with a valid bit.
- Stage 2 computes ed = |z_approx - exact|, a 2*WIDTH unsigned absolute difference. It then updates:
  - sum_ed += ed;
  - max_ed = max(max_ed, ed);
  - err_count += (ed != 0).
- A sample accepted at edge t is reflected in the outputs after edge t+2.

Arithmetic and boundaries:
- sum_ed saturates at 2^ACC_W-1. If the addition would overflow, sum_ed is set to all-ones and sum_sat is set sticky until the next start.
- err_count cannot wrap, because it is bounded by num_samples.
- The maximum ed is 2^(2*WIDTH)-1, so max_ed needs no saturation.
- Asserting rst_n low mid-run aborts immediately: pipeline valid bits, counters and results go to 0, state goes to IDLE, and no done pulse is produced.

Optional Feature:
- Macro: APPROX_MON_BIAS_EN.
- Defined: stage 2 also accumulates the signed difference (z_approx - exact), sign-extended to ACC_W+1 bits, into bias_sum. The accumulator wraps with no saturation; the bench keeps runs within range. It is cleared on start and reset.
- Not defined: bias_sum is tied to 0 and no accumulator is synthesised.

Test Plan:
- Reset, then start with num_samples=1. Send x=3, y=5, z_approx=15 -> done pulses; sum_ed=0, max_ed=0, err_count=0, sum_sat=0.
- start with num_samples=3. Send (x=255,y=255,z=65000), (x=10,y=10,z=112), (x=4,y=4,z=16) -> ed values are 25, 12, 0; sum_ed=37, max_ed=25, err_count=2. With APPROX_MON_BIAS_EN, bias_sum=-13.
- Backpressure/gaps: num_samples=4 with in_valid toggled 1,0,1,1,0,1 -> exactly 4 samples accepted; in_ready=0 from the cycle after the 4th accept; a 5th valid sample is never consumed; done arrives 2-3 cycles after the last accept.
- start with num_samples=0 -> done on the next cycle with all results 0. A start during RUN has no effect on the count or results.
- ACC_W override 8: two samples with ed=200 each -> sum_ed=255, sum_sat=1; sum_sat clears on the next start.
- rst_n pulsed low during RUN after 2 of 5 samples -> all outputs 0 immediately, no done pulse; a new run of 1 sample afterwards completes normally.
